// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: the special instruction
// encodings and the shift that turns a byte address into a word index.
package if_stage_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam int          BYTE_SHIFT = 2;

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and the units around it: the debug
// unit (step, program load, PC/halt observation), the hazard unit (stall),
// the jump/branch resolvers and the decode stage (instruction, pc4).
interface if_stage_if #(
    parameter int NB     = 32,
    parameter int ADDR_W = 8
);

    logic              i_step;
    logic              i_stall;
    logic              i_jump;
    logic [NB-1:0]     i_jump_addr;
    logic              i_branch_taken;
    logic [NB-1:0]     i_branch_addr;
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic [NB-1:0]     i_load_data;
    logic [NB-1:0]     o_instruction;
    logic [NB-1:0]     o_pc4;
    logic [NB-1:0]     o_pc;
    logic              o_halt;

    // Surrounding units drive the controls and observe the fetch outputs.
    modport master (
        output i_step, i_stall, i_jump, i_jump_addr, i_branch_taken,
               i_branch_addr, i_load_en, i_load_addr, i_load_data,
        input  o_instruction, o_pc4, o_pc, o_halt
    );

    // The fetch stage itself.
    modport slave (
        input  i_step, i_stall, i_jump, i_jump_addr, i_branch_taken,
               i_branch_addr, i_load_en, i_load_addr, i_load_data,
        output o_instruction, o_pc4, o_pc, o_halt
    );

endinterface

// File: rtl/if_stage_instruction_memory.sv
// Instruction memory: MEM_DEPTH x NB words, one synchronous write port used
// by the debug loader and one combinational read port used by fetch.
// Contents are never reset so a loaded program survives a core reset.
// A read of the word being written in the same cycle sees the old contents.
module instruction_memory #(
    parameter int NB        = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [NB-1:0]     i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [NB-1:0]     o_rdata
);

    logic [NB-1:0] r_mem [MEM_DEPTH];

    // Debug load port: write one word per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the PC, reads the instruction memory
// combinationally and registers the fetched word and PC+4 into the IF/ID
// boundary. Advances only on a debug step while not halted; redirects
// (branch over jump) squash the boundary and outrank a hazard stall.
// Fetching the HALT word latches it, holds the PC and sets a sticky halt.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int            NB        = 32,
    parameter int            MEM_DEPTH = 256,
    parameter int            ADDR_W    = 8,
    parameter logic [NB-1:0] HALT_WORD = if_stage_pkg::HALT_WORD
) (
    input  logic     i_clk,
    input  logic     i_reset,
    if_stage_if.slave bus
);

    logic [NB-1:0] r_pc;
    logic [NB-1:0] r_instr;
    logic [NB-1:0] r_pc4;
    logic          r_halt;

    logic [NB-1:0]     w_fetch_word;
    logic [ADDR_W-1:0] w_fetch_idx;
    logic [NB-1:0]     w_pc_plus4;
    logic              w_advance;
    logic [NB-1:0]     w_pc_nxt;
    logic [NB-1:0]     w_instr_nxt;
    logic [NB-1:0]     w_pc4_nxt;
    logic              w_halt_nxt;

    // Upper PC bits are dropped here, so fetch wraps modulo MEM_DEPTH words.
    assign w_fetch_idx = r_pc[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
    assign w_pc_plus4  = r_pc + NB'(4);
    assign w_advance   = bus.i_step && !r_halt;

    instruction_memory #(
        .NB       (NB),
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_imem (
        .i_clk  (i_clk),
        .i_we   (bus.i_load_en),
        .i_waddr(bus.i_load_addr),
        .i_wdata(bus.i_load_data),
        .i_raddr(w_fetch_idx),
        .o_rdata(w_fetch_word)
    );

    // Next-PC and IF/ID selection: hold unless advancing, then first match wins.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_halt_nxt  = r_halt;
        if (w_advance) begin
            if (bus.i_branch_taken) begin
                w_pc_nxt    = bus.i_branch_addr;
                w_instr_nxt = NB'(NOP_WORD);
                w_pc4_nxt   = '0;
            end else if (bus.i_jump) begin
                w_pc_nxt    = bus.i_jump_addr;
                w_instr_nxt = NB'(NOP_WORD);
                w_pc4_nxt   = '0;
            end else if (bus.i_stall) begin
                w_pc_nxt    = r_pc;
            end else if (w_fetch_word == HALT_WORD) begin
                w_instr_nxt = HALT_WORD;
                w_pc4_nxt   = w_pc_plus4;
                w_halt_nxt  = 1'b1;
            end else begin
                w_pc_nxt    = w_pc_plus4;
                w_instr_nxt = w_fetch_word;
                w_pc4_nxt   = w_pc_plus4;
            end
        end
    end

    // PC, IF/ID boundary and halt flag; reset returns to PC 0 with a NOP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= '0;
            r_instr <= NB'(NOP_WORD);
            r_pc4   <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    assign bus.o_instruction = r_instr;
    assign bus.o_pc4         = r_pc4;
    assign bus.o_pc          = r_pc;
    assign bus.o_halt        = r_halt;

endmodule
